// File: rtl/lfsr_sample_source.sv
// lfsr_sample_source: emits NUM_SAMPLES LFSR-derived operand pairs over valid/ready, then pulses done
module lfsr_sample_source #(
  parameter int          INPUT_WIDTH = 4,
  parameter int          NUM_SAMPLES = 1024,
  parameter logic [15:0] SEED_A      = 16'h0001,
  parameter logic [15:0] SEED_B      = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [INPUT_WIDTH-1:0]             a,
  output logic [INPUT_WIDTH-1:0]             b,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_count
);
  localparam int CW = $clog2(NUM_SAMPLES+1);
  localparam logic [15:0] SA = (SEED_A == 16'h0) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SB = (SEED_B == 16'h0) ? 16'h0001 : SEED_B;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [15:0] lfsr_a, lfsr_b;
  logic hs, last;
  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  assign hs   = out_valid & out_ready;
  assign last = sample_count == CW'(NUM_SAMPLES - 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (start ? RUN : IDLE) : ((hs && last) ? IDLE : RUN);
  // outputs come straight from registers, so out_ready never reaches them combinationally
  always_comb begin
    out_valid = state == RUN;
    busy      = state == RUN;
    a         = lfsr_a[INPUT_WIDTH-1:0];
    b         = lfsr_b[INPUT_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_a       <= SA;
      lfsr_b       <= SB;
      sample_count <= '0;
      done         <= 1'b0;
    end else begin
      done <= (state == RUN) && hs && last;
      if (state == IDLE && start) begin
        lfsr_a       <= SA;
        lfsr_b       <= SB;
        sample_count <= '0;
      end else if (state == RUN && hs) begin
        lfsr_a       <= step(lfsr_a);
        lfsr_b       <= step(lfsr_b);
        sample_count <= sample_count + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_lfsr_sample_source.sv
// tb_lfsr_sample_source: vector table for cycle-exact behaviour plus a scoreboard over random backpressure
module tb_lfsr_sample_source;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int CW = $clog2(N+1);
  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic out_valid, busy, done, z_valid, z_busy, z_done;
  logic [W-1:0] a, b, za, zb;
  logic [CW-1:0] sample_count, z_count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lfsr_sample_source #(.INPUT_WIDTH(W), .NUM_SAMPLES(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready), .out_valid(out_valid),
    .a(a), .b(b), .busy(busy), .done(done), .sample_count(sample_count));
  lfsr_sample_source #(.INPUT_WIDTH(W), .NUM_SAMPLES(N), .SEED_A(16'h0000)) u_zero (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready), .out_valid(z_valid),
    .a(za), .b(zb), .busy(z_busy), .done(z_done), .sample_count(z_count));
  typedef struct {
    bit st;
    bit rdy;
    bit v;
    int ea;
    int eb;
    bit bz;
    bit dn;
    int cnt;
  } vec_t;
  typedef struct {
    int pa;
    int pb;
  } pair_t;
  vec_t  tbl[19];
  pair_t q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(bit st, bit rdy, bit v, int ea, int eb, bit bz, bit dn, int cnt);
    vec_t r;
    r.st = st; r.rdy = rdy; r.v = v; r.ea = ea; r.eb = eb; r.bz = bz; r.dn = dn; r.cnt = cnt;
    return r;
  endfunction
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  task automatic push_run;
    logic [15:0] ma, mb;
    ma = 16'h0001;
    mb = 16'hACE1;
    for (int i = 0; i < N; i++) begin
      q.push_back('{int'(ma[W-1:0]), int'(mb[W-1:0])});
      ma = lfsr_next(ma);
      mb = lfsr_next(mb);
    end
  endtask
  initial begin
    pair_t p;
    int cycles, dones;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    tick; tick;
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", sample_count, 0);
    rst = 1'b0;
    // basic run, backpressure hold, back-to-back start in done cycle, start while busy
    tbl[0]  = mk(1, 1, 1, 1, 1, 1, 0, 0);
    tbl[1]  = mk(0, 1, 1, 2, 3, 1, 0, 1);
    tbl[2]  = mk(0, 1, 1, 4, 7, 1, 0, 2);
    tbl[3]  = mk(0, 1, 1, 8, 15, 1, 0, 3);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 1, 4);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 4);
    tbl[6]  = mk(1, 0, 1, 1, 1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 1, 2, 3, 1, 0, 1);
    tbl[8]  = mk(0, 0, 1, 2, 3, 1, 0, 1);
    tbl[9]  = mk(0, 0, 1, 2, 3, 1, 0, 1);
    tbl[10] = mk(0, 0, 1, 2, 3, 1, 0, 1);
    tbl[11] = mk(0, 1, 1, 4, 7, 1, 0, 2);
    tbl[12] = mk(0, 1, 1, 8, 15, 1, 0, 3);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 1, 4);
    tbl[14] = mk(1, 1, 1, 1, 1, 1, 0, 0);
    tbl[15] = mk(0, 1, 1, 2, 3, 1, 0, 1);
    tbl[16] = mk(1, 1, 1, 4, 7, 1, 0, 2);
    tbl[17] = mk(1, 1, 1, 8, 15, 1, 0, 3);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 1, 4);
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].st;
      out_ready = tbl[i].rdy;
      tick;
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].v);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("v%0d_done", i), done, tbl[i].dn);
      chk($sformatf("v%0d_count", i), sample_count, tbl[i].cnt);
      if (tbl[i].v) begin
        chk($sformatf("v%0d_a", i), a, tbl[i].ea);
        chk($sformatf("v%0d_b", i), b, tbl[i].eb);
        chk($sformatf("v%0d_zero_seed_a", i), za, tbl[i].ea);
      end
    end
    // reset mid-run after two handshakes, then replay from seeds
    start = 1'b1; out_ready = 1'b1; tick;
    start = 1'b0; tick; tick;
    chk("pre_abort_count", sample_count, 2);
    rst = 1'b1; tick;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", sample_count, 0);
    rst = 1'b0; tick;
    chk("abort_no_done", done, 0);
    chk("abort_idle_valid", out_valid, 0);
    start = 1'b1; tick;
    start = 1'b0;
    chk("replay_a0", a, 1);
    chk("replay_b0", b, 1);
    tick;
    chk("replay_a1", a, 2);
    rst = 1'b1; tick;
    rst = 1'b0;
    // scoreboard runs under random backpressure and stray start pulses
    for (int r = 0; r < 4; r++) begin
      start = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      push_run();
      tick;
      cycles = 0;
      dones = 0;
      while (q.size() > 0 && cycles < 200) begin
        start = ($urandom_range(0, 3) == 0);
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          p = q.pop_front();
          chk($sformatf("sb%0d_a", r), a, p.pa);
          chk($sformatf("sb%0d_b", r), b, p.pb);
        end
        tick;
        if (done) dones++;
        cycles++;
      end
      start = 1'b0;
      if (cycles >= 200) begin
        errors++;
        $display("FAIL sb%0d_timeout pending=%0d expected=0", r, q.size());
        q.delete();
      end
      chk($sformatf("sb%0d_dones", r), dones, 1);
      chk($sformatf("sb%0d_final_count", r), sample_count, N);
      tick;
      chk($sformatf("sb%0d_done_single", r), done, 0);
      chk($sformatf("sb%0d_count_hold", r), sample_count, N);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
